// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - serial frame parity checker with saturating error count
// Accepts FRAME_BITS data bits then one parity bit; reports the result for one cycle.

module parity_frame_checker #(
   parameter int FRAME_BITS = 8,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_bit,
   output logic                 in_ready,
   input  logic                 odd_mode,
   output logic                 done,
   output logic                 parity_ok,
   output logic                 calc_parity,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      CHECK  = 2'd2,
      REPORT = 2'd3
   } state_t;

   localparam logic [7:0]           LAST_IDX   = 8'(FRAME_BITS - 1);
   localparam logic                 SINGLE_BIT = (FRAME_BITS == 1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;
   localparam logic [ERR_CNT_W-1:0] ERR_ONE    = ERR_CNT_W'(1);

   state_t     state;
   state_t     state_nxt;
   logic       acc;
   logic [7:0] bit_cnt;
   logic       accept;

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // bit_cnt holds the number of data bits already taken, so the last data
   // bit is the one accepted while bit_cnt equals FRAME_BITS-1.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      done      = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (accept) begin
               state_nxt = SINGLE_BIT ? CHECK : DATA;
            end
         end
         DATA: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (accept && (bit_cnt == LAST_IDX)) begin
               state_nxt = CHECK;
            end
         end
         CHECK: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (accept) begin
               state_nxt = REPORT;
            end
         end
         REPORT: begin
            done      = 1'b1;
            busy      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // The mode is folded into the accumulator seed, so later odd_mode changes
   // cannot affect the frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc         <= 1'b0;
         bit_cnt     <= 8'd0;
         parity_ok   <= 1'b0;
         calc_parity <= 1'b0;
         err_cnt     <= '0;
      end else if (accept) begin
         case (state)
            IDLE: begin
               acc     <= in_bit ^ odd_mode;
               bit_cnt <= 8'd1;
            end
            DATA: begin
               acc     <= acc ^ in_bit;
               bit_cnt <= bit_cnt + 8'd1;
            end
            CHECK: begin
               calc_parity <= acc;
               parity_ok   <= (acc == in_bit);
               if ((acc != in_bit) && (err_cnt != ERR_MAX)) begin
                  err_cnt <= err_cnt + ERR_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parity_frame_checker.sv
// tb/tb_parity_frame_checker.sv - directed vector bench for parity_frame_checker
// Table of frames with hand-computed results, plus stall, reset and saturation sequences.

module tb_parity_frame_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_bit;
   logic       in_ready;
   logic       odd_mode;
   logic       done;
   logic       parity_ok;
   logic       calc_parity;
   logic [7:0] err_cnt;
   logic       busy;

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;

   parity_frame_checker #(.FRAME_BITS(8), .ERR_CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .in_ready    (in_ready),
      .odd_mode    (odd_mode),
      .done        (done),
      .parity_ok   (parity_ok),
      .calc_parity (calc_parity),
      .err_cnt     (err_cnt),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic       odd;
      logic [7:0] data;   // data[i] is sent i-th
      logic       par;
      logic       exp_ok;
      logic       exp_calc;
      int         exp_err;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Ends one cycle after the parity bit edge, i.e. in the REPORT cycle.
   task automatic send_frame(input logic odd, input logic [7:0] data, input logic par,
                             input int stall_after, output int lat);
      int t0;
      odd_mode = odd;
      t0 = cyc;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_bit   = data[i];
         @(posedge clk); #1;
         if (i == 0) odd_mode = ~odd;
         if (i + 1 == stall_after) begin
            in_valid = 1'b0;
            in_bit   = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk("stall_busy", busy, 1);
            chk("stall_no_done", done, 0);
         end
      end
      in_valid = 1'b1;
      in_bit   = par;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = cyc - t0;
   endtask

   task automatic check_report(input string tag, input logic ok, input logic calc, input int err);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_ready_low"}, in_ready, 0);
      chk({tag, "_parity_ok"}, parity_ok, ok);
      chk({tag, "_calc_parity"}, calc_parity, calc);
      chk({tag, "_err_cnt"}, err_cnt, err);
      @(posedge clk); #1;
      chk({tag, "_done_drop"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int lat;
      int last_done;
      int exp_err;

      vecs[0] = '{odd: 1'b0, data: 8'b0100_1101, par: 1'b0, exp_ok: 1'b1, exp_calc: 1'b0, exp_err: 0};
      vecs[1] = '{odd: 1'b0, data: 8'b0100_1101, par: 1'b1, exp_ok: 1'b0, exp_calc: 1'b0, exp_err: 1};
      vecs[2] = '{odd: 1'b1, data: 8'h00,        par: 1'b1, exp_ok: 1'b1, exp_calc: 1'b1, exp_err: 1};
      vecs[3] = '{odd: 1'b1, data: 8'h00,        par: 1'b0, exp_ok: 1'b0, exp_calc: 1'b1, exp_err: 2};
      vecs[4] = '{odd: 1'b0, data: 8'hFF,        par: 1'b0, exp_ok: 1'b1, exp_calc: 1'b0, exp_err: 2};
      vecs[5] = '{odd: 1'b1, data: 8'h01,        par: 1'b0, exp_ok: 1'b1, exp_calc: 1'b0, exp_err: 2};
      vecs[6] = '{odd: 1'b0, data: 8'h07,        par: 1'b0, exp_ok: 1'b0, exp_calc: 1'b1, exp_err: 3};

      rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1; odd_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_parity_ok", parity_ok, 0);
      chk("rst_calc_parity", calc_parity, 0);
      chk("rst_err_cnt", err_cnt, 0);

      for (int v = 0; v < 7; v++) begin
         send_frame(vecs[v].odd, vecs[v].data, vecs[v].par, 0, lat);
         chk($sformatf("vec%0d_latency", v), lat, 9);
         check_report($sformatf("vec%0d", v), vecs[v].exp_ok, vecs[v].exp_calc, vecs[v].exp_err);
      end

      send_frame(1'b0, 8'b0100_1101, 1'b0, 4, lat);
      chk("stall_latency", lat, 12);
      check_report("stall", 1'b1, 1'b0, 3);

      // Reset mid-frame with err_cnt at 1 and a transfer offered on the reset edge.
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      send_frame(1'b0, 8'h00, 1'b1, 0, lat);
      check_report("pre_rst", 1'b0, 1'b0, 1);
      odd_mode = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_bit = 1'b1;
         @(posedge clk); #1;
      end
      chk("mid_busy", busy, 1);
      rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_err_cnt", err_cnt, 0);
      chk("midrst_ready", in_ready, 1);
      chk("midrst_done", done, 0);
      send_frame(1'b0, 8'b0100_1101, 1'b0, 0, lat);
      check_report("post_rst", 1'b1, 1'b0, 0);

      // 257 bad frames back to back; the next frame's first bit is offered during REPORT.
      odd_mode = 1'b0;
      last_done = 0;
      for (int f = 0; f < 257; f++) begin
         for (int b = 0; b < 9; b++) begin
            in_valid = 1'b1;
            in_bit   = (b == 8);
            @(posedge clk); #1;
         end
         exp_err = (f + 1 > 255) ? 255 : f + 1;
         chk($sformatf("sat%0d_done", f), done, 1);
         chk($sformatf("sat%0d_err_cnt", f), err_cnt, exp_err);
         if (f > 0) chk($sformatf("sat%0d_period", f), cyc - last_done, 10);
         last_done = cyc;
         in_bit = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("sat_final_err_cnt", err_cnt, 255);
      chk("sat_final_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 Parameter FRAME_BITS, default 8, number of data bits per frame (legal range 1..255).
REQ-002 Parameter ERR_CNT_W, default 8, width of the error counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_bit carries a valid serial bit this cycle.
REQ-006 in_bit  input  1  serial bit: FRAME_BITS data bits, then 1 received parity bit.
REQ-007 in_ready  output  1  block can accept a bit this cycle.
REQ-008 odd_mode  input  1  0 = even parity, 1 = odd parity; sampled only on acceptance of data bit 0.
REQ-009 done  output  1  single-cycle pulse: frame result valid.
REQ-010 parity_ok  output  1  last frame's received parity matched computed parity.
REQ-011 calc_parity  output  1  last frame's computed parity bit.
REQ-012 err_cnt  output  ERR_CNT_W  count of frames with parity mismatch, saturating.
REQ-013 busy  output  1  high while a frame is partially received (states DATA, CHECK, REPORT).

Function
REQ-014 Transfer: a bit is accepted on a rising edge only when in_valid && in_ready; in_bit is ignored otherwise, X-tolerant.
REQ-015 FSM states: IDLE, DATA, CHECK, REPORT; in_ready = 1 in IDLE, DATA and CHECK, 0 in REPORT.
REQ-016 IDLE: on accept, acc <= in_bit ^ odd_mode, mode latched, bit_cnt <= 1; next DATA, or CHECK if FRAME_BITS == 1.
REQ-017 DATA: on accept, acc <= acc ^ in_bit, bit_cnt increments; after the FRAME_BITS-th data bit, next CHECK.
REQ-018 CHECK: accepted bit is the received parity; calc_parity <= acc, parity_ok <= (acc == in_bit); next REPORT.
REQ-019 REPORT: lasts exactly one cycle, done = 1; next IDLE unconditionally.
REQ-020 Latency: done asserts in the cycle immediately after the parity bit is accepted; parity_ok and calc_parity are valid in that cycle.
REQ-021 parity_ok and calc_parity hold their values until the next frame's REPORT.
REQ-022 err_cnt increments by 1 on entry to REPORT when parity_ok is 0; it saturates at 2^ERR_CNT_W-1 and never wraps.
REQ-023 in_valid low in any state stalls: no state, acc or bit_cnt change.
REQ-024 bit_cnt is 8 bits wide; there is no timeout and a stalled frame waits indefinitely.
REQ-025 Back-to-back frames: a bit offered during REPORT is not accepted and is taken in the following IDLE cycle.
REQ-026 odd_mode changes mid-frame have no effect on the current frame.

Reset
REQ-027 While rst is high at a rising edge: state <= IDLE, acc <= 0, bit_cnt <= 0, done <= 0, parity_ok <= 0, calc_parity <= 0, err_cnt <= 0, busy <= 0.
REQ-028 Reset overrides any simultaneous transfer; a partial frame is discarded and not counted.
REQ-029 in_ready is 1 in the first cycle after rst deasserts.

Verification
REQ-030 Even mode, FRAME_BITS=8, data 1,0,1,1,0,0,1,0 then parity 0 -> done one cycle after the parity bit, calc_parity=0, parity_ok=1, err_cnt=0.
REQ-031 Same data with parity 1 -> parity_ok=0, calc_parity=0, err_cnt=1.
REQ-032 odd_mode=1, data all zeros, parity 1 -> parity_ok=1, calc_parity=1; repeat with parity 0 -> parity_ok=0.
REQ-033 Insert in_valid=0 for 3 cycles after bit 4 of the REQ-030 frame -> identical result; done is delayed by exactly 3 cycles.
REQ-034 Assert rst after 4 data bits with err_cnt=1 -> next cycle IDLE, err_cnt=0, busy=0; a following clean frame gives parity_ok=1.
REQ-035 ERR_CNT_W=8, 257 consecutive bad frames with in_valid held high -> err_cnt reaches 255 and stays 255; done pulses every 10 cycles.
